// File: rtl/sp_grouper.sv
// sp_grouper: serial-to-parallel input stage of the 16-point radix-4 FFT.
// It collects one complex sample per accepted cycle. Samples x[0..11] are
// stored. Each of x[12..15] is forwarded together with three stored samples,
// so the block emits group g = {x[g], x[g+4], x[g+8], x[g+12]} on the cycle
// after sample 12+g is accepted.
module sp_grouper #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din_r,
  input  logic [WIDTH-1:0] din_i,
  output logic             out_valid,
  output logic [1:0]       out_grp,
  output logic             s_p_flag,
  output logic [WIDTH-1:0] dout0_r,
  output logic [WIDTH-1:0] dout0_i,
  output logic [WIDTH-1:0] dout1_r,
  output logic [WIDTH-1:0] dout1_i,
  output logic [WIDTH-1:0] dout2_r,
  output logic [WIDTH-1:0] dout2_i,
  output logic [WIDTH-1:0] dout3_r,
  output logic [WIDTH-1:0] dout3_i,
  output logic [3:0]       frame_cnt
);

  localparam int NSTORE = 12;

  logic [3:0]       cnt_r;
  logic [WIDTH-1:0] mem_re_r [NSTORE];
  logic [WIDTH-1:0] mem_im_r [NSTORE];
  logic [WIDTH-1:0] lane_re_r [4];
  logic [WIDTH-1:0] lane_im_r [4];
  logic             out_valid_r;
  logic [1:0]       out_grp_r;
  logic             s_p_flag_r;

  logic             accept_s;
  logic             emit_s;
  logic [1:0]       grp_s;
  logic [WIDTH-1:0] sel_re_s [3];
  logic [WIDTH-1:0] sel_im_s [3];

  // A resync on the same cycle wins over the sample, which is then dropped.
  assign accept_s = in_valid & ~sync_clr;
  // Counts 12..15 are the forwarded samples; each one completes a group.
  assign emit_s   = accept_s & (cnt_r >= 4'd12);
  assign grp_s    = cnt_r[1:0];

  // Pick the three stored operands of the group selected by the low count bits.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      sel_re_s[j] = mem_re_r[4*j];
      sel_im_s[j] = mem_im_r[4*j];
      case (grp_s)
        2'd0: begin
          sel_re_s[j] = mem_re_r[4*j];
          sel_im_s[j] = mem_im_r[4*j];
        end
        2'd1: begin
          sel_re_s[j] = mem_re_r[4*j+1];
          sel_im_s[j] = mem_im_r[4*j+1];
        end
        2'd2: begin
          sel_re_s[j] = mem_re_r[4*j+2];
          sel_im_s[j] = mem_im_r[4*j+2];
        end
        2'd3: begin
          sel_re_s[j] = mem_re_r[4*j+3];
          sel_im_s[j] = mem_im_r[4*j+3];
        end
        default: begin
          sel_re_s[j] = mem_re_r[4*j];
          sel_im_s[j] = mem_im_r[4*j];
        end
      endcase
    end
  end

  // Sample counter: advances on every accepted sample, 15 wraps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (sync_clr) begin
      cnt_r <= 4'd0;
    end else if (in_valid) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sample store for x[0..11]. A resync leaves the contents in place because
  // they are rewritten before the next frame reads them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTORE; i++) begin
        mem_re_r[i] <= '0;
        mem_im_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSTORE; i++) begin
        if (accept_s && (cnt_r == 4'(i))) begin
          mem_re_r[i] <= din_r;
          mem_im_r[i] <= din_i;
        end else begin
          mem_re_r[i] <= mem_re_r[i];
          mem_im_r[i] <= mem_im_r[i];
        end
      end
    end
  end

  // Lane data and group index load on an emitted group and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 4; j++) begin
        lane_re_r[j] <= '0;
        lane_im_r[j] <= '0;
      end
      out_grp_r <= 2'd0;
    end else if (emit_s) begin
      for (int j = 0; j < 3; j++) begin
        lane_re_r[j] <= sel_re_s[j];
        lane_im_r[j] <= sel_im_s[j];
      end
      lane_re_r[3] <= din_r;
      lane_im_r[3] <= din_i;
      out_grp_r    <= grp_s;
    end else begin
      for (int j = 0; j < 4; j++) begin
        lane_re_r[j] <= lane_re_r[j];
        lane_im_r[j] <= lane_im_r[j];
      end
      out_grp_r <= out_grp_r;
    end
  end

  // Valid strobe and frame-start pulse. Both are single-cycle because they
  // follow emit_s directly, and emit_s is already low during a resync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      s_p_flag_r  <= 1'b0;
    end else begin
      out_valid_r <= emit_s;
      s_p_flag_r  <= emit_s & (grp_s == 2'd0);
    end
  end

  assign out_valid = out_valid_r;
  assign out_grp   = out_grp_r;
  assign s_p_flag  = s_p_flag_r;
  assign frame_cnt = cnt_r;
  assign dout0_r   = lane_re_r[0];
  assign dout0_i   = lane_im_r[0];
  assign dout1_r   = lane_re_r[1];
  assign dout1_i   = lane_im_r[1];
  assign dout2_r   = lane_re_r[2];
  assign dout2_i   = lane_im_r[2];
  assign dout3_r   = lane_re_r[3];
  assign dout3_i   = lane_im_r[3];

endmodule

// File: tb/tb_sp_grouper.sv
// Self-checking bench for sp_grouper: table-driven frame vectors, directed
// corner sequences and randomized traffic against a frame-level model.
module tb_sp_grouper;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n, sync_clr, in_valid;
  logic [W-1:0] din_r, din_i;
  logic         out_valid, s_p_flag;
  logic [1:0]   out_grp;
  logic [3:0]   frame_cnt;
  logic [W-1:0] dout0_r, dout0_i, dout1_r, dout1_i, dout2_r, dout2_i, dout3_r, dout3_i;

  sp_grouper #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid),
    .din_r(din_r), .din_i(din_i), .out_valid(out_valid), .out_grp(out_grp),
    .s_p_flag(s_p_flag),
    .dout0_r(dout0_r), .dout0_i(dout0_i), .dout1_r(dout1_r), .dout1_i(dout1_i),
    .dout2_r(dout2_r), .dout2_i(dout2_i), .dout3_r(dout3_r), .dout3_i(dout3_i),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: the frame's samples, how many have been accepted, and
  // the group the outputs should show.
  logic [W-1:0] m_xr [16];
  logic [W-1:0] m_xi [16];
  int           m_k;
  logic         m_valid, m_flag;
  int           m_grp;
  logic [W-1:0] m_lr [4];
  logic [W-1:0] m_li [4];

  logic [W-1:0] act_r [4];
  logic [W-1:0] act_i [4];
  always_comb begin
    act_r[0] = dout0_r; act_r[1] = dout1_r; act_r[2] = dout2_r; act_r[3] = dout3_r;
    act_i[0] = dout0_i; act_i[1] = dout1_i; act_i[2] = dout2_i; act_i[3] = dout3_i;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m_xr[i] = '0; m_xi[i] = '0; end
    for (int j = 0; j < 4; j++) begin m_lr[j] = '0; m_li[j] = '0; end
    m_k = 0; m_valid = 1'b0; m_flag = 1'b0; m_grp = 0;
  endtask

  task automatic model_edge(input logic v, input logic clr, input logic [W-1:0] dr, input logic [W-1:0] di);
    m_valid = 1'b0;
    m_flag  = 1'b0;
    if (clr) begin
      m_k = 0;
    end else if (v) begin
      m_xr[m_k] = dr;
      m_xi[m_k] = di;
      if (m_k >= 12) begin
        m_grp   = m_k - 12;
        m_valid = 1'b1;
        m_flag  = (m_grp == 0);
        for (int j = 0; j < 4; j++) begin
          m_lr[j] = m_xr[m_grp + 4*j];
          m_li[j] = m_xi[m_grp + 4*j];
        end
      end
      m_k = (m_k + 1) % 16;
    end
  endtask

  task automatic model_compare();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("s_p_flag", 32'(s_p_flag), 32'(m_flag));
    chk("out_grp", 32'(out_grp), 32'(m_grp));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_k));
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("dout%0d_r", j), 32'(act_r[j]), 32'(m_lr[j]));
      chk($sformatf("dout%0d_i", j), 32'(act_i[j]), 32'(m_li[j]));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " s_p_flag"}, 32'(s_p_flag), 32'd0);
    chk({tag, " out_grp"}, 32'(out_grp), 32'd0);
    chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'd0);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("%s dout%0d_r", tag, j), 32'(act_r[j]), 32'd0);
      chk($sformatf("%s dout%0d_i", tag, j), 32'(act_i[j]), 32'd0);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic v, input logic clr, input logic [W-1:0] dr, input logic [W-1:0] di);
    in_valid = v; sync_clr = clr; din_r = dr; din_i = di;
    @(posedge clk);
    model_edge(v, clr, dr, di);
    cyc++;
    #1;
    model_compare();
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] dr, di;
    logic         e_valid, e_flag;
    logic [1:0]   e_grp;
    logic [3:0]   e_cnt;
    logic [W-1:0] e_r [4];
    logic [W-1:0] e_i [4];
  } vec_t;

  vec_t vt [17];
  int   flag_cyc [$];
  int   nflag;

  initial begin
    // Continuous frame x[k] = (k, -k), followed by one idle cycle.
    for (int k = 0; k < 17; k++) begin
      int g;
      g = (k >= 12 && k < 16) ? k - 12 : 3;
      vt[k].v       = (k < 16);
      vt[k].dr      = W'(k);
      vt[k].di      = W'(-k);
      vt[k].e_valid = (k >= 12 && k < 16);
      vt[k].e_flag  = (k == 12);
      vt[k].e_grp   = (k >= 12) ? 2'(g) : 2'd0;
      vt[k].e_cnt   = 4'((k + 1) % 16);
      if (k == 16) vt[k].e_cnt = 4'd0;
      for (int j = 0; j < 4; j++) begin
        vt[k].e_r[j] = (k >= 12) ? W'(g + 4*j) : '0;
        vt[k].e_i[j] = (k >= 12) ? W'(-(g + 4*j)) : '0;
      end
    end

    // Reset held with live input: everything stays at zero.
    model_reset();
    rst_n = 1'b0; sync_clr = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_r = W'($urandom); din_i = W'($urandom);
      @(posedge clk); #1;
    end
    check_zero("reset_hold");
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;

    // Table-driven continuous frame.
    for (int k = 0; k < 17; k++) begin
      step(vt[k].v, 1'b0, vt[k].dr, vt[k].di);
      chk($sformatf("tbl%0d valid", k), 32'(out_valid), 32'(vt[k].e_valid));
      chk($sformatf("tbl%0d flag", k), 32'(s_p_flag), 32'(vt[k].e_flag));
      chk($sformatf("tbl%0d cnt", k), 32'(frame_cnt), 32'(vt[k].e_cnt));
      if (k >= 12) begin
        chk($sformatf("tbl%0d grp", k), 32'(out_grp), 32'(vt[k].e_grp));
        for (int j = 0; j < 4; j++) begin
          chk($sformatf("tbl%0d lane%0d_r", k, j), 32'(act_r[j]), 32'(vt[k].e_r[j]));
          chk($sformatf("tbl%0d lane%0d_i", k, j), 32'(act_i[j]), 32'(vt[k].e_i[j]));
        end
      end
    end

    // Back-to-back frames: flags 16 cycles apart, second group 0 from 100+k.
    flag_cyc.delete();
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 1'b0, (k < 16) ? W'(k) : W'(100 + k - 16), W'(0));
      if (s_p_flag) flag_cyc.push_back(cyc);
      if (k == 15) begin
        chk("b2b g3 r0", 32'(dout0_r), 32'd3);
        chk("b2b g3 r3", 32'(dout3_r), 32'd15);
      end
      if (k == 28) begin
        chk("b2b f2 r0", 32'(dout0_r), 32'd100);
        chk("b2b f2 r1", 32'(dout1_r), 32'd104);
        chk("b2b f2 r2", 32'(dout2_r), 32'd108);
        chk("b2b f2 r3", 32'(dout3_r), 32'd112);
      end
    end
    chk("b2b flag count", 32'(flag_cyc.size()), 32'd2);
    if (flag_cyc.size() == 2) chk("b2b flag spacing", 32'(flag_cyc[1] - flag_cyc[0]), 32'd16);

    // Gapped input: two idle cycles between samples 13 and 14.
    nflag = 0;
    for (int k = 0; k < 14; k++) begin
      step(1'b1, 1'b0, W'(k), W'(k));
      if (s_p_flag) nflag++;
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, W'($urandom), W'($urandom));
      chk("gap valid", 32'(out_valid), 32'd0);
      chk("gap grp hold", 32'(out_grp), 32'd1);
      chk("gap r0 hold", 32'(dout0_r), 32'd1);
      chk("gap r3 hold", 32'(dout3_r), 32'd13);
    end
    for (int k = 14; k < 16; k++) begin
      step(1'b1, 1'b0, W'(k), W'(k));
      if (s_p_flag) nflag++;
      chk("gap resume grp", 32'(out_grp), 32'(k - 12));
    end
    chk("gap flag count", 32'(nflag), 32'd1);

    // Resync after 7 samples; the sample offered with sync_clr is dropped.
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, W'(50 + k), W'(0));
    step(1'b1, 1'b1, W'(16'h0BAD), W'(16'h0BAD));
    chk("resync cnt", 32'(frame_cnt), 32'd0);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, W'(200 + k), W'(0));
      if (k == 12) begin
        chk("resync g0 r0", 32'(dout0_r), 32'd200);
        chk("resync g0 r1", 32'(dout1_r), 32'd204);
        chk("resync g0 r2", 32'(dout2_r), 32'd208);
        chk("resync g0 r3", 32'(dout3_r), 32'd212);
      end
    end

    // Width extremes: alternating 0x7FFF / 0x8000.
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, k[0] ? 16'h8000 : 16'h7FFF, k[0] ? 16'h7FFF : 16'h8000);
      if (k == 12) begin
        chk("ext g0 r0", 32'(dout0_r), 32'h7FFF);
        chk("ext g0 i3", 32'(dout3_i), 32'h8000);
      end
      if (k == 13) begin
        chk("ext g1 r3", 32'(dout3_r), 32'h8000);
        chk("ext g1 i0", 32'(dout0_i), 32'h7FFF);
      end
    end

    // Randomized traffic with gaps and occasional resync.
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           W'($urandom), W'($urandom));
    end

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    for (int k = 0; k < 13; k++) step(1'b1, 1'b0, W'(k + 1), W'(k + 1));
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, W'(300 + k), W'(k));
    step(1'b0, 1'b0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sp_grouper.md
# sp_grouper

Serial-to-parallel input stage of the 16-point radix-4 FFT core. Accepts one complex sample per valid cycle and emits each 16-sample frame as four parallel groups of four lanes, where group g is {x[g], x[g+4], x[g+8], x[g+12]}, the first-stage radix-4 butterfly operands. It drives the control unit's start flag, which pulses when the 13th sample of a frame is accepted. It also feeds the butterfly input mux with group data.

## Interface
- WIDTH, 16, bit width of each real/imag component (signed two's complement, passed through unmodified)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sync_clr  in  1  synchronous frame resync; discards partial frame
- in_valid  in  1  din_r/din_i carry a valid sample this cycle
- din_r  in  WIDTH  sample real part
- din_i  in  WIDTH  sample imaginary part
- out_valid  out  1  lane outputs hold a valid group
- out_grp  out  2  group index g of current lane outputs
- s_p_flag  out  1  one-cycle pulse, frame's 13th sample accepted (group 0 on outputs)
- dout0_r/dout0_i … dout3_r/dout3_i  out  WIDTH each  lane j = x[out_grp + 4j]
- frame_cnt  out  4  number of samples of current frame accepted so far (0–15)

## Operation
- Storage: 12 complex registers mem[0..11] hold x[0..11]; x[12..15] are never stored, only forwarded.
- Sample counter cnt (4 bits) = frame_cnt. On an edge with in_valid=1 and sync_clr=0, the block performs the following:
  - cnt ≤ 11: mem[cnt] ← din; cnt ← cnt+1.
  - cnt = 12+g (g=0..3): dout0 ← mem[g], dout1 ← mem[g+4], dout2 ← mem[g+8], dout3 ← din; out_grp ← g; out_valid ← 1; cnt ← cnt+1 (15 wraps to 0).
- Edge without an emitted group (in_valid=0, or cnt ≤ 11): out_valid ← 0. Lane data and out_grp hold their last value.
- s_p_flag ← 1 exactly on the edge that emits group 0, else 0. Invariant: s_p_flag = out_valid & (out_grp==0).
- There is no overwrite hazard. Next-frame writes to mem[0] occur only after cnt wraps, which is after all groups of the current frame are emitted.
- sync_clr=1 has priority over in_valid. It sets cnt ← 0, out_valid ← 0, s_p_flag ← 0, and the sample presented that cycle is dropped. mem is not cleared.
- Gaps: in_valid low stalls everything. Groups are emitted only on accepted samples, so a gap between samples 12..15 produces gaps between groups.
- No backpressure. The downstream must consume a group in the cycle out_valid is high.

## Timing
- Reset (rst_n=0, asynchronous): cnt=0, mem=0, out_valid=0, s_p_flag=0, out_grp=0, all dout=0, frame_cnt=0. Reset mid-frame discards the partial frame; the first post-reset sample is x[0].
- Latency: group g appears on outputs the cycle after the edge that accepts sample 12+g. With continuous input, groups 0..3 appear on 4 consecutive cycles.
- Throughput: one frame per 16 accepted samples. Back-to-back frames need no idle cycles.
- s_p_flag is high for exactly 1 cycle per frame. Downstream control counts 3 further group cycles from it.

## Test plan
- Reset values: hold rst_n=0 while in_valid=1 and random din -> all outputs 0. Assert rst_n low asynchronously mid-cycle -> outputs clear immediately without waiting for a clock edge.
- Continuous frame: din_r=k, din_i=-k for k=0..15 on consecutive cycles.
  - Cycle after k=12: out_valid=1, s_p_flag=1, out_grp=0, dout_r={0,4,8,12}, dout_i={0,-4,-8,-12}.
  - Next three cycles: groups 1..3 with dout_r {1,5,9,13}, {2,6,10,14}, {3,7,11,15}, and s_p_flag=0.
  - Following cycle: out_valid=0.
- Back-to-back frames: 32 continuous samples, second frame din_r=100+k -> second group 0 = {100,104,108,112}, exactly 16 cycles after the first s_p_flag. No corruption of the first frame's group 3 ({3,7,11,15}).
- Gapped input: drop in_valid for 2 cycles between samples 13 and 14 -> group 1 emitted, then out_valid=0 for 2 cycles, then groups 2, 3. Lane data and out_grp hold during the gap. s_p_flag pulses once.
- Resync: after 7 samples assert sync_clr with in_valid=1 -> frame_cnt=0 and that sample dropped. Next 16 samples (din_r=200+k) -> group 0 = {200,204,208,212}.
- Width boundary: WIDTH=16, samples 0x7FFF / 0x8000 alternating -> lanes reproduce values bit-exactly, with no sign or truncation change.
